// File: rtl/fp_add_pkg.sv
// Shared constants and state encoding for the floating-point add sequencer.
package fp_add_pkg;

  localparam int unsigned EXP_W     = 8;
  localparam int unsigned SIG_W     = 24;
  localparam int unsigned MAX_ALIGN = 26;
  localparam int unsigned CNT_W     = $clog2(MAX_ALIGN + 1);
  localparam int unsigned SHL_W     = $clog2(SIG_W + 1);

  typedef enum logic [3:0] {
    StIdle,
    StLoad,
    StCmp,
    StAlign,
    StAdd,
    StNorm,
    StRound,
    StRchk,
    StDone
  } fp_add_state_t;

endpackage

// File: rtl/fp_align_counter.sv
// Alignment shift counter: loads min(|exp_diff|, MAX_ALIGN) and counts down to the last shift.
module fp_align_counter
  import fp_add_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [EXP_W-1:0] exp_diff_i,
  output logic             load_zero_o,
  output logic             last_o
);

  logic [EXP_W-1:0] mag;
  logic [CNT_W-1:0] sat;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    // -128 folds to 8'h80, read as unsigned 128, which saturates below
    mag = exp_diff_i[EXP_W-1] ? (~exp_diff_i + EXP_W'(1)) : exp_diff_i;
    sat = (mag > EXP_W'(MAX_ALIGN)) ? CNT_W'(MAX_ALIGN) : mag[CNT_W-1:0];
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = sat;
    end else if (dec_i) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign load_zero_o = (sat == '0);
  assign last_o      = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/fp_add_control.sv
// Sequencer for the single-precision add datapath: compare, align, add, normalize, round.
module fp_add_control
  import fp_add_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [EXP_W-1:0] exp_diff,
  input  logic             sig_msb,
  input  logic             sig_ovf,
  input  logic             sig_zero,
  input  logic             exp_ovf,
  input  logic             exp_unf,
  output logic             ready,
  output logic             load_in,
  output logic             sel_swap,
  output logic             shift_r_small,
  output logic             add_en,
  output logic             norm_shift_r,
  output logic             norm_shift_l,
  output logic             exp_inc,
  output logic             exp_dec,
  output logic             round_en,
  output logic             load_out,
  output logic             done,
  output logic             ovf_flag,
  output logic             unf_flag,
  output logic             zero_flag
);

  fp_add_state_t    state_d, state_q;
  logic             sel_swap_d, sel_swap_q;
  logic             ovf_d, ovf_q, unf_d, unf_q, zero_d, zero_q;
  logic             renorm_d, renorm_q;
  logic [SHL_W-1:0] shl_cnt_d, shl_cnt_q;
  logic             cnt_load, cnt_dec, cnt_load_zero, cnt_last;

  fp_align_counter u_align_counter (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .load_i      (cnt_load),
    .dec_i       (cnt_dec),
    .exp_diff_i  (exp_diff),
    .load_zero_o (cnt_load_zero),
    .last_o      (cnt_last)
  );

  always_comb begin
    state_d       = state_q;
    sel_swap_d    = sel_swap_q;
    ovf_d         = ovf_q;
    unf_d         = unf_q;
    zero_d        = zero_q;
    renorm_d      = renorm_q;
    shl_cnt_d     = shl_cnt_q;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;
    ready         = 1'b0;
    load_in       = 1'b0;
    shift_r_small = 1'b0;
    add_en        = 1'b0;
    norm_shift_r  = 1'b0;
    norm_shift_l  = 1'b0;
    exp_inc       = 1'b0;
    exp_dec       = 1'b0;
    round_en      = 1'b0;
    load_out      = 1'b0;
    done          = 1'b0;

    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (start) begin
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          zero_d  = 1'b0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        load_in   = 1'b1;
        shl_cnt_d = '0;
        renorm_d  = 1'b0;
        state_d   = StCmp;
      end
      StCmp: begin
        sel_swap_d = exp_diff[EXP_W-1];
        cnt_load   = 1'b1;
        state_d    = cnt_load_zero ? StAdd : StAlign;
      end
      StAlign: begin
        shift_r_small = 1'b1;
        cnt_dec       = 1'b1;
        if (cnt_last) begin
          state_d = StAdd;
        end
      end
      StAdd: begin
        add_en  = 1'b1;
        state_d = StNorm;
      end
      StNorm: begin
        if (exp_ovf) begin
          ovf_d   = 1'b1;
          state_d = StDone;
        end else if (exp_unf) begin
          unf_d   = 1'b1;
          state_d = StDone;
        end else if (sig_zero) begin
          zero_d  = 1'b1;
          state_d = StDone;
        end else if (sig_ovf) begin
          norm_shift_r = 1'b1;
          exp_inc      = 1'b1;
        end else if (!sig_msb) begin
          norm_shift_l = 1'b1;
          exp_dec      = 1'b1;
          shl_cnt_d    = shl_cnt_q + SHL_W'(1);
          // A full significand width of left shifts without a leading one means zero
          if (shl_cnt_q == SHL_W'(SIG_W - 1)) begin
            zero_d  = 1'b1;
            state_d = StDone;
          end
        end else begin
          state_d = StRound;
        end
      end
      StRound: begin
        round_en = 1'b1;
        state_d  = StRchk;
      end
      StRchk: begin
        if (sig_ovf && !renorm_q) begin
          renorm_d = 1'b1;
          state_d  = StNorm;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        load_out = 1'b1;
        done     = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sel_swap_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      zero_q     <= 1'b0;
      renorm_q   <= 1'b0;
      shl_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sel_swap_q <= sel_swap_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      zero_q     <= zero_d;
      renorm_q   <= renorm_d;
      shl_cnt_q  <= shl_cnt_d;
    end
  end

  assign sel_swap  = sel_swap_q;
  assign ovf_flag  = ovf_q;
  assign unf_flag  = unf_q;
  assign zero_flag = zero_q;

endmodule

// File: tb/tb_fp_add_control.sv
// Bench for fp_add_control: builds each operation's expected cycle trace from the sequencing rules.
module tb_fp_add_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] exp_diff = '0;
  logic       sig_msb = 1'b0, sig_ovf = 1'b0, sig_zero = 1'b0, exp_ovf = 1'b0, exp_unf = 1'b0;
  logic       ready, load_in, sel_swap, shift_r_small, add_en, norm_shift_r, norm_shift_l;
  logic       exp_inc, exp_dec, round_en, load_out, done, ovf_flag, unf_flag, zero_flag;

  always #5 clk = ~clk;

  fp_add_control dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .exp_diff      (exp_diff),
    .sig_msb       (sig_msb),
    .sig_ovf       (sig_ovf),
    .sig_zero      (sig_zero),
    .exp_ovf       (exp_ovf),
    .exp_unf       (exp_unf),
    .ready         (ready),
    .load_in       (load_in),
    .sel_swap      (sel_swap),
    .shift_r_small (shift_r_small),
    .add_en        (add_en),
    .norm_shift_r  (norm_shift_r),
    .norm_shift_l  (norm_shift_l),
    .exp_inc       (exp_inc),
    .exp_dec       (exp_dec),
    .round_en      (round_en),
    .load_out      (load_out),
    .done          (done),
    .ovf_flag      (ovf_flag),
    .unf_flag      (unf_flag),
    .zero_flag     (zero_flag)
  );

  // Output bits: ready load_in shift_r_small add_en nsr nsl inc dec round load_out done
  localparam logic [10:0] O_NONE  = 11'h000;
  localparam logic [10:0] O_IDLE  = 11'h400;
  localparam logic [10:0] O_LOAD  = 11'h200;
  localparam logic [10:0] O_ALIGN = 11'h100;
  localparam logic [10:0] O_ADD   = 11'h080;
  localparam logic [10:0] O_SHR   = 11'h050;
  localparam logic [10:0] O_SHL   = 11'h028;
  localparam logic [10:0] O_ROUND = 11'h004;
  localparam logic [10:0] O_DONE  = 11'h003;

  // stat bits: sig_msb sig_ovf sig_zero exp_ovf exp_unf; flags: ovf unf zero
  typedef struct packed {
    logic        start;
    logic [4:0]  stat;
    logic [10:0] outs;
    logic [2:0]  flags;
    logic        swap;
  } rec_t;

  rec_t       sched[$];
  logic [2:0] model_flags = '0;
  logic       model_swap = 1'b0;
  logic [7:0] cur_diff = '0;
  int         checks = 0;
  int         failures = 0;

  function automatic logic [4:0] rnd5();
    return 5'($urandom);
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic push(input logic st, input logic [4:0] stat, input logic [10:0] outs);
    rec_t r;
    r.start = st;
    r.stat  = stat;
    r.outs  = outs;
    r.flags = model_flags;
    r.swap  = model_swap;
    sched.push_back(r);
  endtask

  // term: 0 normal exit, 1 exp_ovf, 2 exp_unf, 3 sig_zero; l==24 ends in zero via shift limit
  task automatic build_op(input logic [7:0] ed, input int r, input int l, input int term,
                          input bit renorm);
    int  d, n;
    bit  limit_hit;
    sched.delete();
    cur_diff = ed;
    d = int'($signed(ed));
    n = (d < 0) ? -d : d;
    if (n > 26) n = 26;
    limit_hit = 1'b0;
    push(1'b1, rnd5(), O_IDLE);
    model_flags = '0;
    push(rb(), rnd5(), O_LOAD);
    push(rb(), rnd5(), O_NONE);
    model_swap = ed[7];
    for (int i = 0; i < n; i++) push(rb(), rnd5(), O_ALIGN);
    push(rb(), rnd5(), O_ADD);
    for (int i = 0; i < r; i++) push(rb(), {rb(), 4'b1000}, O_SHR);
    for (int i = 0; i < l; i++) begin
      push(rb(), 5'b00000, O_SHL);
      if (i == 23) begin
        model_flags[0] = 1'b1;
        limit_hit = 1'b1;
        break;
      end
    end
    if (!limit_hit) begin
      case (term)
        1: begin push(rb(), {rnd5() | 5'b00010}, O_NONE); model_flags[2] = 1'b1; end
        2: begin push(rb(), {rb(), rb(), rb(), 2'b01}, O_NONE); model_flags[1] = 1'b1; end
        3: begin push(rb(), {rb(), rb(), 3'b100}, O_NONE); model_flags[0] = 1'b1; end
        default: begin
          push(rb(), 5'b10000, O_NONE);
          push(rb(), rnd5(), O_ROUND);
          push(rb(), {rb(), renorm, rb(), rb(), rb()}, O_NONE);
          if (renorm) begin
            push(rb(), {rb(), 4'b1000}, O_SHR);
            push(rb(), 5'b10000, O_NONE);
            push(rb(), rnd5(), O_ROUND);
            push(rb(), {rb(), 1'b1, rb(), rb(), rb()}, O_NONE);
          end
        end
      endcase
    end
    push(rb(), rnd5(), O_DONE);
    push(1'b0, rnd5(), O_IDLE);
  endtask

  function automatic logic [10:0] dut_outs();
    return {ready, load_in, shift_r_small, add_en, norm_shift_r, norm_shift_l,
            exp_inc, exp_dec, round_en, load_out, done};
  endfunction

  task automatic compare(input string tag, input int idx, input rec_t r);
    checks += 3;
    assert (dut_outs() === r.outs) else begin
      failures++;
      $error("FAIL %s strobes cyc=%0d got=%h exp=%h", tag, idx, dut_outs(), r.outs);
    end
    assert ({ovf_flag, unf_flag, zero_flag} === r.flags) else begin
      failures++;
      $error("FAIL %s flags cyc=%0d got=%b exp=%b", tag, idx, {ovf_flag, unf_flag, zero_flag},
             r.flags);
    end
    assert (sel_swap === r.swap) else begin
      failures++;
      $error("FAIL %s sel_swap cyc=%0d got=%b exp=%b", tag, idx, sel_swap, r.swap);
    end
  endtask

  // Called at posedge+1; replays the schedule. rst_at >= 0 aborts with a reset at that cycle.
  task automatic run(input string tag, input int rst_at);
    rec_t r;
    for (int i = 0; i < sched.size(); i++) begin
      r = sched[i];
      start    = r.start;
      exp_diff = cur_diff;
      {sig_msb, sig_ovf, sig_zero, exp_ovf, exp_unf} = r.stat;
      if (i == rst_at) begin
        #1 rst_n = 1'b0;
        model_flags = '0;
        model_swap  = 1'b0;
        r.outs = O_IDLE; r.flags = '0; r.swap = 1'b0;
        #1 compare({tag, "_rst"}, i, r);
        @(negedge clk) compare({tag, "_rsthold"}, i, r);
        @(posedge clk) #1 compare({tag, "_rstedge"}, i, r);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk) compare({tag, "_rstrel"}, i, r);
        @(posedge clk) #1;
        return;
      end
      @(negedge clk) compare(tag, i, r);
      @(posedge clk) #1;
    end
    start = 1'b0;
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(posedge clk) #1;

    build_op(8'd0, 0, 0, 0, 1'b0);   run("basic", -1);
    build_op(8'd3, 0, 0, 0, 1'b0);   run("align3", -1);
    build_op(8'hFB, 0, 0, 0, 1'b0);  run("alignm5", -1);
    build_op(8'd100, 0, 0, 0, 1'b0); run("align100", -1);
    build_op(8'h80, 0, 0, 0, 1'b0);  run("alignm128", -1);
    build_op(8'h1A, 0, 0, 0, 1'b0);  run("align26", -1);
    build_op(8'd0, 0, 2, 0, 1'b1);   run("renorm", -1);
    build_op(8'd1, 1, 1, 0, 1'b0);   run("shr_shl", -1);
    build_op(8'd0, 0, 0, 1, 1'b0);   run("ovf", -1);
    build_op(8'd2, 0, 0, 3, 1'b0);   run("zero", -1);
    build_op(8'hFF, 1, 0, 2, 1'b0);  run("unf", -1);
    build_op(8'd0, 0, 24, 0, 1'b0);  run("shl_limit", -1);
    build_op(8'd10, 0, 0, 0, 1'b0);  run("midreset", 5);
    build_op(8'd0, 0, 0, 0, 1'b0);   run("after_rst", -1);

    for (int k = 0; k < 40; k++) begin
      build_op(8'($urandom), $urandom_range(0, 2), ($urandom_range(0, 9) == 0) ? 24 :
               $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom));
      run("rand", ($urandom_range(0, 7) == 0) ? $urandom_range(1, 6) : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
